// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the program ROM and the decoder.
// Holds the program counter, drives the ROM address from it, and captures each
// returned instruction together with its fetch address into a one-entry output
// slot that the decoder drains through a valid/ready handshake. Jumps redirect
// the PC and flush the slot; halt freezes fetching. A jump outside the program
// raises a sticky fault and parks the stage in HALT.
module instr_fetch #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 18,
  parameter int RESET_PC = 0,
  parameter int PROG_LEN = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_instr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  input  logic               i_jump,
  input  logic [ADDR_W-1:0]  i_jump_addr,
  input  logic               i_halt,
  output logic               o_halted,
  output logic               o_fault
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Last legal ROM address, and the program length widened by one bit so that
  // a jump target equal to 2**ADDR_W-1 still compares correctly.
  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W:0]   LP_PROG_LEN  = (ADDR_W + 1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] LP_RESET_PC  = ADDR_W'(RESET_PC);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_opc;
  logic               r_fault;

  logic               w_slot_free;
  logic               w_consume;
  logic               w_jump_legal;
  logic [ADDR_W-1:0]  w_pc_next;

  // Handshake qualifiers, jump target range check and the wrapping PC increment.
  always_comb begin
    w_slot_free  = !r_valid || i_ready;
    w_consume    = r_valid && i_ready;
    w_jump_legal = ({1'b0, i_jump_addr} < LP_PROG_LEN);
    w_pc_next    = (r_pc == LP_LAST_ADDR) ? '0 : (r_pc + ADDR_W'(1));
  end

  // Fetch control: reset, then jump, then halt, then normal fetch/stall, all
  // resolved in one registered state machine so every output comes from a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_pc    <= LP_RESET_PC;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_opc   <= '0;
      r_fault <= 1'b0;
    end else if (i_jump) begin
      // The slot is flushed even if the decoder is accepting it this cycle:
      // whatever sits there belongs to the abandoned path.
      r_valid <= 1'b0;
      if (w_jump_legal) begin
        r_pc    <= i_jump_addr;
        r_state <= ST_RUN;
      end else begin
        r_fault <= 1'b1;
        r_state <= ST_HALT;
      end
    end else if (r_state == ST_RUN && i_halt) begin
      // Stop without fetching; a pending entry may still drain this edge.
      r_state <= ST_HALT;
      if (w_consume) begin
        r_valid <= 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      if (w_slot_free) begin
        r_instr <= i_rom_instr;
        r_opc   <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= w_pc_next;
      end
    end else begin
      // Halted: nothing new is fetched, only the leftover entry drains.
      if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rom_addr = r_pc;
  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_opc;
  assign o_halted   = (r_state == ST_HALT);
  assign o_fault    = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for the fetch stage with a small ROM model.
module tb_instr_fetch;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 18;

  logic               clk;
  logic               rst;
  logic [ADDR_W-1:0]  romAddr;
  logic [INSTR_W-1:0] romInstr;
  logic               valid;
  logic               ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  pc;
  logic               jump;
  logic [ADDR_W-1:0]  jumpAddr;
  logic               halt;
  logic               halted;
  logic               fault;

  int testsRun;
  int testsFailed;

  logic [INSTR_W-1:0] rom [0:7];

  instr_fetch #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0), .PROG_LEN(7)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .o_rom_addr(romAddr),
    .i_rom_instr(romInstr),
    .o_valid(valid),
    .i_ready(ready),
    .o_instr(instr),
    .o_pc(pc),
    .i_jump(jump),
    .i_jump_addr(jumpAddr),
    .i_halt(halt),
    .o_halted(halted),
    .o_fault(fault)
  );

  // Combinational ROM answering the stage's address.
  assign romInstr = (romAddr < 16'd8) ? rom[romAddr[2:0]] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then settle past it.
  task automatic applyStimulus(input logic r, input logic rdy, input logic j,
                               input logic [ADDR_W-1:0] ja, input logic h);
    rst      = r;
    ready    = rdy;
    jump     = j;
    jumpAddr = ja;
    halt     = h;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rom[0] = 18'h01111;
    rom[1] = 18'h02222;
    rom[2] = 18'h03333;
    rom[3] = 18'h04444;
    rom[4] = 18'b111010010000000000;
    rom[5] = 18'h05555;
    rom[6] = 18'h06666;
    rom[7] = 18'h3FFFF;

    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("rst_valid",   32'(valid),   32'd0);
    checkOutput("rst_instr",   32'(instr),   32'd0);
    checkOutput("rst_pc",      32'(pc),      32'd0);
    checkOutput("rst_fault",   32'(fault),   32'd0);
    checkOutput("rst_halted",  32'(halted),  32'd0);
    checkOutput("rst_romaddr", 32'(romAddr), 32'd0);

    // Streaming with wrap: 0..6 then 0
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
      checkOutput($sformatf("seq%0d_valid", i), 32'(valid), 32'd1);
      checkOutput($sformatf("seq%0d_pc", i),    32'(pc),    32'(i % 7));
      checkOutput($sformatf("seq%0d_instr", i), 32'(instr), 32'(rom[i % 7]));
    end
    checkOutput("seq_pc4_word", 32'(rom[4]), 32'h3A400);

    // Stall at pc2
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("pre_stall_pc", 32'(pc), 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      checkOutput($sformatf("stall%0d_valid", i),   32'(valid),   32'd1);
      checkOutput($sformatf("stall%0d_pc", i),      32'(pc),      32'd2);
      checkOutput($sformatf("stall%0d_instr", i),   32'(instr),   32'h03333);
      checkOutput($sformatf("stall%0d_romaddr", i), 32'(romAddr), 32'd3);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("release_pc",      32'(pc),      32'd3);
    checkOutput("release_romaddr", 32'(romAddr), 32'd4);

    // Jump to 4 while the slot is being accepted
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd4, 1'b0);
    checkOutput("jmp_flush_valid", 32'(valid),   32'd0);
    checkOutput("jmp_romaddr",     32'(romAddr), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("jmp_tgt_valid", 32'(valid),       32'd1);
    checkOutput("jmp_tgt_pc",    32'(pc),          32'd4);
    checkOutput("jmp_tgt_op",    32'(instr[13:10]), 32'd9);

    // Halt with an un-accepted entry at pc1
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    checkOutput("hlt_pre_pc", 32'(pc), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    checkOutput("hlt_halted",  32'(halted),  32'd1);
    checkOutput("hlt_valid",   32'(valid),   32'd1);
    checkOutput("hlt_pc",      32'(pc),      32'd1);
    checkOutput("hlt_romaddr", 32'(romAddr), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    checkOutput("hlt_hold_valid", 32'(valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("hlt_drain_valid",  32'(valid),  32'd0);
    checkOutput("hlt_drain_halted", 32'(halted), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("hlt_nofetch_valid", 32'(valid),   32'd0);
    checkOutput("hlt_frozen_pc",     32'(romAddr), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0, 1'b0);
    checkOutput("resume_halted", 32'(halted),  32'd0);
    checkOutput("resume_valid",  32'(valid),   32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("resume_valid2", 32'(valid), 32'd1);
    checkOutput("resume_pc",     32'(pc),    32'd0);
    checkOutput("resume_instr",  32'(instr), 32'h01111);

    // Illegal jump target
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd7, 1'b0);
    checkOutput("flt_fault",   32'(fault),   32'd1);
    checkOutput("flt_halted",  32'(halted),  32'd1);
    checkOutput("flt_valid",   32'(valid),   32'd0);
    checkOutput("flt_romaddr", 32'(romAddr), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
    checkOutput("flt_sticky", 32'(fault),  32'd1);
    checkOutput("flt_leave",  32'(halted), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("flt_rst_fault",  32'(fault),  32'd0);
    checkOutput("flt_rst_halted", 32'(halted), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("flt_restart_pc",    32'(pc),    32'd0);
    checkOutput("flt_restart_valid", 32'(valid), 32'd1);

    // Reset beats a simultaneous jump
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("midrst_pre_pc", 32'(pc), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'd5, 1'b0);
    checkOutput("midrst_valid",   32'(valid),   32'd0);
    checkOutput("midrst_romaddr", 32'(romAddr), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("midrst_pc0", 32'(pc), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("midrst_pc1", 32'(pc), 32'd1);

    // Jump to the last word, then fetch wraps to 0
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd6, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("wrap_pc6", 32'(pc), 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    checkOutput("wrap_pc0",    32'(pc),    32'd0);
    checkOutput("wrap_instr0", 32'(instr), 32'h01111);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
